port_arbiter: RTL
=================

# port_arbiter

Two-requester arbiter and bus sequencer for a memory-mapped GPIO port block. It accepts single-word read/write requests from two masters (CPU bus interface on requester 0, auxiliary master on requester 1), grants them round-robin, and drives the port's chip-select, write-enable, output-enable, register select and write data through a fixed SETUP/STROBE/HOLD sequence. Read data is captured from the port during STROBE and returned to the granted requester.

## Interface
- DATA_WIDTH, `DATA_WIDTH: width of data paths.
- ADDR_WIDTH, 2: register select width (0x0 PORT, 0x1 PDDR, 0x2/0x3 reserved; not decoded here).

- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- req0 / req1  input  1  access request from requester 0 / 1.
- we0 / we1  input  1  1 = write, 0 = read.
- addr0 / addr1  input  ADDR_WIDTH  register select.
- wdata0 / wdata1  input  DATA_WIDTH  write data.
- gnt0 / gnt1  output  1  high for the whole access owned by that requester.
- done0 / done1  output  1  one-cycle pulse in the HOLD cycle.
- rdata  output  DATA_WIDTH  last read data; valid when doneN is high on a read.
- busy  output  1  high whenever state is not IDLE.
- port_cs, port_we, port_oe  output  1  port strobes.
- port_addr  output  ADDR_WIDTH  register select to port.
- port_wdata  output  DATA_WIDTH  data to port.
- port_rdata  input  DATA_WIDTH  data from port (undriven unless port_cs & port_oe).

## Operation
- States: IDLE, SETUP, STROBE, HOLD (2-bit encoding).
- IDLE: if any req high at clock edge, pick winner, register owner, we, addr, wdata into internal holding regs, go SETUP; else stay.
- SETUP -> STROBE -> HOLD -> IDLE unconditionally; no early exit, no back-to-back arbitration from HOLD.
- Arbitration: round-robin via `last` bit (owner of previous completed grant). Only one req high: it wins. Both high: requester != last wins. Reset sets last = 1 so requester 0 wins the first tie.
- `last` updates on IDLE->SETUP edge to the new owner.
- Request fields are sampled only at grant; changes after grant are ignored. Dropping req mid-access does not abort it.
- Outputs per state: SETUP: port_cs=1, port_we=0, port_oe=0. STROBE: port_cs=1, port_we=we_h, port_oe=!we_h. HOLD: port_cs=1, port_we=0, port_oe=0. IDLE: all 0.
- port_addr / port_wdata driven from holding regs in SETUP/STROBE/HOLD; 0 in IDLE.
- Read: rdata <= port_rdata at STROBE->HOLD edge. rdata unchanged by writes; holds value until next read.
- gntN = busy & (owner == N); doneN = (state == HOLD) & (owner == N). All outputs registered or decoded from registered state only (no combinational path from req/port_rdata to outputs).
- Invariant: port_we & port_oe never both 1; port_we/port_oe only asserted with port_cs.
- Reserved addresses passed through unchanged.

## Timing
- Reset values (while reset=0): state IDLE, all outputs 0, rdata 0, last 1, holding regs 0.
- reset asserted mid-access: strobes drop in the same cycle asynchronously; access abandoned, no doneN pulse; after release, arbitration restarts in IDLE.
- reqN high at edge E0 (state IDLE): gntN high cycles 1-3, SETUP cycle 1, STROBE cycle 2, HOLD cycle 3 with doneN=1 and (read) rdata valid; IDLE at cycle 4.
- Minimum spacing between accesses: 4 cycles (IDLE cycle between accesses mandatory).
- Requester must deassert req by the edge after doneN or it is re-granted (subject to round-robin) in the following IDLE cycle.
- Continuous req0 & req1: grants alternate 0,1,0,1..., each 4 cycles.

## Test plan
- Reset: hold reset=0 with req0=req1=1 -> all outputs 0, busy 0; release -> gnt0 rises one cycle after first edge.
- Single write: req0=1, we0=1, addr0=1, wdata0=8'hA5 -> cycle 2 port_cs=1, port_we=1, port_addr=1, port_wdata=8'hA5; done0 in cycle 3; port_oe never 1.
- Single read: req1=1, we1=0, addr1=0, port_rdata=8'h3C during STROBE -> port_oe=1 cycle 2 only; rdata=8'h3C with done1 in cycle 3; rdata retained after subsequent write.
- Contention: req0=req1=1 held 16 cycles -> grant order 0,1,0,1, done pulses every 4 cycles, never both gnt high.
- Field change/abort: change addr0/wdata0 and drop req0 during STROBE -> port_addr/port_wdata unchanged, done0 still pulses.
- Mid-access reset: reset=0 during STROBE -> port_cs/port_we/port_oe drop same cycle, no done pulse, next grant after release goes to requester 0 on tie.

Source files
------------

// File: rtl/port_arbiter_if.sv
// Requester and port-side signal bundle for the two-master GPIO port arbiter.
// The master side drives requests and port read data; the arbiter owns the rest.
interface port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) ();
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  done0;
    logic                  done1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic                  port_cs;
    logic                  port_we;
    logic                  port_oe;
    logic [ADDR_WIDTH-1:0] port_addr;
    logic [DATA_WIDTH-1:0] port_wdata;
    logic [DATA_WIDTH-1:0] port_rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, port_rdata,
        input  gnt0, gnt1, done0, done1, rdata, busy,
        input  port_cs, port_we, port_oe, port_addr, port_wdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, port_rdata,
        output gnt0, gnt1, done0, done1, rdata, busy,
        output port_cs, port_we, port_oe, port_addr, port_wdata
    );
endinterface

// File: rtl/port_arbiter.sv
// Round-robin arbiter for two single-word masters, sequencing each access to
// the GPIO port as SETUP/STROBE/HOLD. Every output is a flop fed from next-state.
module port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  busy_q, busy_d;
    logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                  done0_q, done0_d, done1_q, done1_d;
    logic                  cs_q, cs_d, pwe_q, pwe_d, poe_q, poe_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  win_s;
    logic                  active_s;

    // Requester 1 wins when it is alone or when requester 0 held the previous grant.
    assign win_s = bus.req1 & (~bus.req0 | ~last_q);

    // Next-state, holding-register capture and next output values.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    state_d = SETUP;
                    owner_d = win_s;
                    last_d  = win_s;
                    we_d    = win_s ? bus.we1    : bus.we0;
                    addr_d  = win_s ? bus.addr1  : bus.addr0;
                    wdata_d = win_s ? bus.wdata1 : bus.wdata0;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: begin
                state_d = HOLD;
                if (!we_q) begin
                    rdata_d = bus.port_rdata;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        active_s = (state_d != IDLE);
        busy_d   = active_s;
        gnt0_d   = active_s & ~owner_d;
        gnt1_d   = active_s & owner_d;
        done0_d  = (state_d == HOLD) & ~owner_d;
        done1_d  = (state_d == HOLD) & owner_d;
        cs_d     = active_s;
        pwe_d    = (state_d == STROBE) & we_d;
        poe_d    = (state_d == STROBE) & ~we_d;
        paddr_d  = active_s ? addr_d  : {ADDR_WIDTH{1'b0}};
        pwdata_d = active_s ? wdata_d : {DATA_WIDTH{1'b0}};
    end

    // State, holding registers and registered outputs; reset clears strobes immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= {ADDR_WIDTH{1'b0}};
            wdata_q  <= {DATA_WIDTH{1'b0}};
            rdata_q  <= {DATA_WIDTH{1'b0}};
            busy_q   <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            cs_q     <= 1'b0;
            pwe_q    <= 1'b0;
            poe_q    <= 1'b0;
            paddr_q  <= {ADDR_WIDTH{1'b0}};
            pwdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            cs_q     <= cs_d;
            pwe_q    <= pwe_d;
            poe_q    <= poe_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.done0      = done0_q;
    assign bus.done1      = done1_q;
    assign bus.rdata      = rdata_q;
    assign bus.port_cs    = cs_q;
    assign bus.port_we    = pwe_q;
    assign bus.port_oe    = poe_q;
    assign bus.port_addr  = paddr_q;
    assign bus.port_wdata = pwdata_q;
endmodule
